// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//
// Operand-issue stage in front of a registered 32-bit ALU. Incoming commands
// are buffered in a small FIFO. One operand set at a time is presented to the
// ALU and held there. The block waits out the ALU's result latency (1 cycle)
// and zero-flag latency (2 cycles), then returns a registered response over a
// valid/ready handshake.
//
// Optional feature (macro ALU_ISSUE_SELCHK_EN):
//   A popped command whose select is above 3'b101 is not issued. The block
//   answers it directly with r=0, zflag=1, err=1 and leaves o_alu_* untouched.
//   Without the macro every select is issued and o_rsp_err is tied 0.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   i_cmd_valid / o_cmd_ready   command handshake into the FIFO
//   i_cmd_a, i_cmd_b, i_cmd_sel command operands and operation select
//   o_alu_a, o_alu_b, o_alu_sel operands held at the ALU inputs
//   i_alu_r, i_alu_zflag        ALU result (+1 cycle) and zero flag (+2 cycles)
//   o_rsp_valid / i_rsp_ready   response handshake
//   o_rsp_r, o_rsp_zflag        captured result and zero flag
//   o_rsp_err                   illegal select (only with ALU_ISSUE_SELCHK_EN)
//   o_busy                      FSM not idle or FIFO not empty
//   o_count                     FIFO occupancy
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 3,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_cmd_valid,
    output logic                   o_cmd_ready,
    input  logic [DATA_W-1:0]      i_cmd_a,
    input  logic [DATA_W-1:0]      i_cmd_b,
    input  logic [SEL_W-1:0]       i_cmd_sel,
    output logic [DATA_W-1:0]      o_alu_a,
    output logic [DATA_W-1:0]      o_alu_b,
    output logic [SEL_W-1:0]       o_alu_sel,
    input  logic [DATA_W-1:0]      i_alu_r,
    input  logic                   i_alu_zflag,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic [DATA_W-1:0]      o_rsp_r,
    output logic                   o_rsp_zflag,
    output logic                   o_rsp_err,
    output logic                   o_busy,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_R,
        WAIT_Z,
        RESP
    } state_t;

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] a;
    } cmd_t;

    state_t           state;
    state_t           state_nxt;
    cmd_t             fifo_mem [DEPTH];
    cmd_t             cmd_in;
    cmd_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             pop_bad;
    logic             capture;
    logic             rsp_clear;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    assign o_cmd_ready = (count < CNT_W'(DEPTH));
    assign push        = i_cmd_valid & o_cmd_ready;
    assign cmd_in      = '{sel: i_cmd_sel, b: i_cmd_b, a: i_cmd_a};
    assign head        = fifo_mem[rd_ptr];
    assign o_count     = count;
    assign o_busy      = (state != IDLE) || (count != '0);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap by overflowing.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; validity is tracked entirely by
    // count/pointers, so resetting it would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= cmd_in;
    end

    // ------------------------------------------------------------------
    // Select check
    // ------------------------------------------------------------------
`ifdef ALU_ISSUE_SELCHK_EN
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(5);
    assign pop_bad = (head.sel > SEL_MAX);
`else
    assign pop_bad = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: next state and per-cycle strobes
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        capture   = 1'b0;
        rsp_clear = 1'b0;
        case (state)
            IDLE: begin
                // count is registered, so a command pushed into an empty FIFO
                // becomes poppable one cycle later.
                if (count != '0) pop = 1'b1;
            end
            ISSUE:  state_nxt = WAIT_R;
            WAIT_R: state_nxt = WAIT_Z;
            WAIT_Z: begin
                // Result and flag are both settled from the held operands.
                capture   = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                if (i_rsp_ready) begin
                    rsp_clear = 1'b1;
                    state_nxt = IDLE;
                    if (count != '0) pop = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Any pop either starts an issue or, for a rejected select,
        // answers immediately.
        if (pop) state_nxt = pop_bad ? RESP : ISSUE;
    end

    // ------------------------------------------------------------------
    // State, ALU operand and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            o_alu_a     <= '0;
            o_alu_b     <= '0;
            o_alu_sel   <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_r     <= '0;
            o_rsp_zflag <= 1'b0;
        end else begin
            state <= state_nxt;
            // Operands stay put between pops; the ALU re-samples each cycle.
            if (pop && !pop_bad) begin
                o_alu_a   <= head.a;
                o_alu_b   <= head.b;
                o_alu_sel <= head.sel;
            end
            if (rsp_clear) o_rsp_valid <= 1'b0;
            // A rejected command popped at a handshake edge re-asserts valid,
            // so this must follow the clear.
            if (capture) begin
                o_rsp_valid <= 1'b1;
                o_rsp_r     <= i_alu_r;
                o_rsp_zflag <= i_alu_zflag;
            end else if (pop && pop_bad) begin
                o_rsp_valid <= 1'b1;
                o_rsp_r     <= '0;
                o_rsp_zflag <= 1'b1;
            end
        end
    end

`ifdef ALU_ISSUE_SELCHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rsp_err <= 1'b0;
        end else if (capture) begin
            o_rsp_err <= 1'b0;
        end else if (pop && pop_bad) begin
            o_rsp_err <= 1'b1;
        end
    end
`else
    assign o_rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
//
// Directed bench for alu_issue_ctrl with a registered ALU model attached.
// A table of hand-computed vectors covers the ALU operations. Hand-written
// sequences cover latency, backpressure/full, simultaneous push/pop with
// pointer wrap, reset mid-operation and the illegal select. A handshake
// monitor checks every accepted response against an expectation queue.
// Honours ALU_ISSUE_SELCHK_EN when compiled with it.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;

    localparam int DATA_W = 32;
    localparam int SEL_W  = 3;
    localparam int DEPTH  = 4;

`ifdef ALU_ISSUE_SELCHK_EN
    localparam bit SELCHK = 1'b1;
`else
    localparam bit SELCHK = 1'b0;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  sel;
        logic [31:0] r;
        logic        z;
    } vec_t;

    typedef struct {
        logic [31:0] r;
        logic        z;
        logic        err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_cmd_valid = 1'b0;
    logic              o_cmd_ready;
    logic [DATA_W-1:0] i_cmd_a = '0;
    logic [DATA_W-1:0] i_cmd_b = '0;
    logic [SEL_W-1:0]  i_cmd_sel = '0;
    logic [DATA_W-1:0] o_alu_a;
    logic [DATA_W-1:0] o_alu_b;
    logic [SEL_W-1:0]  o_alu_sel;
    logic [DATA_W-1:0] i_alu_r;
    logic              i_alu_zflag;
    logic              o_rsp_valid;
    logic              i_rsp_ready = 1'b0;
    logic [DATA_W-1:0] o_rsp_r;
    logic              o_rsp_zflag;
    logic              o_rsp_err;
    logic              o_busy;
    logic [$clog2(DEPTH):0] o_count;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    vec_t vecs[11];

    always #5 clk = ~clk;

    alu_issue_ctrl #(
        .DATA_W(DATA_W),
        .SEL_W (SEL_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_cmd_valid(i_cmd_valid),
        .o_cmd_ready(o_cmd_ready),
        .i_cmd_a    (i_cmd_a),
        .i_cmd_b    (i_cmd_b),
        .i_cmd_sel  (i_cmd_sel),
        .o_alu_a    (o_alu_a),
        .o_alu_b    (o_alu_b),
        .o_alu_sel  (o_alu_sel),
        .i_alu_r    (i_alu_r),
        .i_alu_zflag(i_alu_zflag),
        .o_rsp_valid(o_rsp_valid),
        .i_rsp_ready(i_rsp_ready),
        .o_rsp_r    (o_rsp_r),
        .o_rsp_zflag(o_rsp_zflag),
        .o_rsp_err  (o_rsp_err),
        .o_busy     (o_busy),
        .o_count    (o_count)
    );

    // Registered ALU: result one cycle after operands, flag from the result.
    function automatic logic [31:0] alu_f(logic [31:0] a, logic [31:0] b, logic [2:0] sel);
        case (sel)
            3'b000:  return a + b;
            3'b001:  return a & b;
            3'b010:  return a | b;
            3'b011:  return a * b;
            3'b100:  return a - b;
            3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        i_alu_r     <= alu_f(o_alu_a, o_alu_b, o_alu_sel);
        i_alu_zflag <= (i_alu_r == 32'd0);
        cyc         <= cyc + 1;
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every response taken by the consumer must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && o_rsp_valid && i_rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got response r=%0h with no command pending", o_rsp_r);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_r", o_rsp_r, e.r);
                check("sb_z", 32'(o_rsp_zflag), 32'(e.z));
                check("sb_err", 32'(o_rsp_err), 32'(e.err));
            end
        end
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(logic [31:0] a, logic [31:0] b, logic [2:0] sel,
                        logic [31:0] er, logic ez, logic eerr);
        int w = 0;
        exp_t e;
        while (!o_cmd_ready && w < 50) begin
            step();
            w++;
        end
        check("send_ready", 32'(o_cmd_ready), 32'd1);
        e.r = er;
        e.z = ez;
        e.err = eerr;
        exp_q.push_back(e);
        i_cmd_a = a;
        i_cmd_b = b;
        i_cmd_sel = sel;
        i_cmd_valid = 1'b1;
        step();
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int w = 0;
        while (!o_rsp_valid && w < 40) begin
            step();
            w++;
        end
        check("rsp_valid_wait", 32'(o_rsp_valid), 32'd1);
    endtask

    task automatic handshake();
        i_rsp_ready = 1'b1;
        step();
        i_rsp_ready = 1'b0;
    endtask

    task automatic check_reset(string tag);
        check({tag, "_count"}, 32'(o_count), 32'd0);
        check({tag, "_cmd_ready"}, 32'(o_cmd_ready), 32'd1);
        check({tag, "_alu_a"}, o_alu_a, 32'd0);
        check({tag, "_alu_b"}, o_alu_b, 32'd0);
        check({tag, "_alu_sel"}, 32'(o_alu_sel), 32'd0);
        check({tag, "_rsp_valid"}, 32'(o_rsp_valid), 32'd0);
        check({tag, "_rsp_r"}, o_rsp_r, 32'd0);
        check({tag, "_rsp_z"}, 32'(o_rsp_zflag), 32'd0);
        check({tag, "_rsp_err"}, 32'(o_rsp_err), 32'd0);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prev_a;
        logic [31:0] prev_b;
        logic [2:0]  prev_sel;
        logic [31:0] held_r;
        int          accepted;
        int          last_cyc;
        int          w;

        // a, b, sel, expected r, expected zflag
        vecs[0]  = '{32'd5,        32'd7,        3'b000, 32'd12,         1'b0};
        vecs[1]  = '{32'd9,        32'd9,        3'b100, 32'd0,          1'b1};
        vecs[2]  = '{32'd3,        32'd4,        3'b101, 32'd1,          1'b0};
        vecs[3]  = '{32'h0000F0F0, 32'h00000FF0, 3'b001, 32'h000000F0,   1'b0};
        vecs[4]  = '{32'h0000F000, 32'h0000000F, 3'b010, 32'h0000F00F,   1'b0};
        vecs[5]  = '{32'd6,        32'd7,        3'b011, 32'd42,         1'b0};
        vecs[6]  = '{32'h0000FFFF, 32'h00010000, 3'b011, 32'hFFFF0000,   1'b0};
        vecs[7]  = '{32'd10,       32'd3,        3'b100, 32'd7,          1'b0};
        vecs[8]  = '{32'd8,        32'd3,        3'b101, 32'd0,          1'b1};
        vecs[9]  = '{32'd1,        32'd2,        3'b110, 32'd0,          1'b1};
        vecs[10] = '{32'hFFFFFFFF, 32'd1,        3'b000, 32'd0,          1'b1};

        // Reset state
        #22;
        check_reset("rst");
        rst_n = 1'b1;
        step();
        check_reset("post_rst");

        // Single add: operands one cycle after the push edge, valid after edge t+4
        send(32'd5, 32'd7, 3'b000, 32'd12, 1'b0, 1'b0);
        check("lat_count", 32'(o_count), 32'd1);
        step();
        check("lat_alu_a", o_alu_a, 32'd5);
        check("lat_alu_b", o_alu_b, 32'd7);
        check("lat_alu_sel", 32'(o_alu_sel), 32'd0);
        check("lat_valid_t1", 32'(o_rsp_valid), 32'd0);
        step(2);
        check("lat_valid_t3", 32'(o_rsp_valid), 32'd0);
        step();
        check("lat_valid_t4", 32'(o_rsp_valid), 32'd1);
        check("lat_r", o_rsp_r, 32'd12);
        check("lat_z", 32'(o_rsp_zflag), 32'd0);
        handshake();
        check("lat_valid_clr", 32'(o_rsp_valid), 32'd0);
        check("lat_busy", 32'(o_busy), 32'd0);

        // Table of operations
        for (int i = 0; i < 11; i++) begin
            logic verr;
            verr = SELCHK && (vecs[i].sel > 3'b101);
            send(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].r, vecs[i].z, verr);
            wait_valid();
            check($sformatf("vec%0d_r", i), o_rsp_r, vecs[i].r);
            check($sformatf("vec%0d_z", i), 32'(o_rsp_zflag), 32'(vecs[i].z));
            check($sformatf("vec%0d_err", i), 32'(o_rsp_err), 32'(verr));
            handshake();
        end

        // Illegal select
        prev_a = o_alu_a;
        prev_b = o_alu_b;
        prev_sel = o_alu_sel;
        send(32'd11, 32'd22, 3'b111, 32'd0, 1'b1, SELCHK);
        step();
        if (SELCHK) begin
            check("ill_valid", 32'(o_rsp_valid), 32'd1);
            check("ill_alu_a_held", o_alu_a, prev_a);
            check("ill_alu_b_held", o_alu_b, prev_b);
            check("ill_alu_sel_held", 32'(o_alu_sel), 32'(prev_sel));
        end else begin
            check("ill_alu_a", o_alu_a, 32'd11);
            check("ill_alu_sel", 32'(o_alu_sel), 32'd7);
            step(3);
            check("ill_valid", 32'(o_rsp_valid), 32'd1);
        end
        check("ill_r", o_rsp_r, 32'd0);
        check("ill_z", 32'(o_rsp_zflag), 32'd1);
        check("ill_err", 32'(o_rsp_err), 32'(SELCHK));
        handshake();

        // Backpressure / full: six attempts, five accepted (one in flight, four queued)
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            logic acc;
            exp_t e;
            i_cmd_a = 32'd100 + 32'(i);
            i_cmd_b = 32'(i);
            i_cmd_sel = 3'b000;
            i_cmd_valid = 1'b1;
            acc = o_cmd_ready;
            if (acc) begin
                e.r = i_cmd_a + i_cmd_b;
                e.z = 1'b0;
                e.err = 1'b0;
                exp_q.push_back(e);
                accepted++;
            end
            step();
        end
        i_cmd_valid = 1'b0;
        check("full_accepted", 32'(accepted), 32'd5);
        check("full_count", 32'(o_count), 32'd4);
        check("full_cmd_ready", 32'(o_cmd_ready), 32'd0);
        wait_valid();
        held_r = o_rsp_r;
        step(2);
        check("bp_valid_held", 32'(o_rsp_valid), 32'd1);
        check("bp_r_held", o_rsp_r, held_r);
        check("bp_r_first", o_rsp_r, 32'd100);

        // Drain in order; one response every 4 cycles
        i_rsp_ready = 1'b1;
        last_cyc = 0;
        for (int n = 0; n < 5; n++) begin
            wait_valid();
            if (n > 0) check($sformatf("tput_%0d", n), 32'(cyc - last_cyc), 32'd4);
            last_cyc = cyc;
            step();
            if (n == 0) begin
                check("drain_cmd_ready", 32'(o_cmd_ready), 32'd1);
                check("drain_count", 32'(o_count), 32'd3);
            end
        end
        i_rsp_ready = 1'b0;
        check("drain_sb_empty", 32'(exp_q.size()), 32'd0);

        // Simultaneous push and handshake-pop: count unchanged
        send(32'd1, 32'd1, 3'b000, 32'd2, 1'b0, 1'b0);
        send(32'd2, 32'd2, 3'b000, 32'd4, 1'b0, 1'b0);
        send(32'd3, 32'd3, 3'b000, 32'd6, 1'b0, 1'b0);
        wait_valid();
        check("pp_count_before", 32'(o_count), 32'd2);
        begin
            exp_t e;
            e.r = 32'd8;
            e.z = 1'b0;
            e.err = 1'b0;
            exp_q.push_back(e);
        end
        i_cmd_a = 32'd4;
        i_cmd_b = 32'd4;
        i_cmd_sel = 3'b000;
        i_cmd_valid = 1'b1;
        i_rsp_ready = 1'b1;
        step();
        i_cmd_valid = 1'b0;
        check("pp_count_after", 32'(o_count), 32'd2);

        // Stream of 10 more commands with the consumer always ready (pointer wrap)
        for (int i = 0; i < 10; i++) begin
            send(32'd1000 + 32'(i * 3), 32'd7, 3'b000, 32'd1007 + 32'(i * 3), 1'b0, 1'b0);
        end
        w = 0;
        while (o_busy && w < 200) begin
            step();
            w++;
        end
        i_rsp_ready = 1'b0;
        check("wrap_idle", 32'(o_busy), 32'd0);
        check("wrap_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset in WAIT_R with two commands queued
        send(32'd50, 32'd1, 3'b000, 32'd51, 1'b0, 1'b0);
        send(32'd60, 32'd1, 3'b000, 32'd61, 1'b0, 1'b0);
        send(32'd70, 32'd1, 3'b000, 32'd71, 1'b0, 1'b0);
        check("mid_count", 32'(o_count), 32'd2);
        check("mid_alu_a", o_alu_a, 32'd50);
        rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        exp_q.delete();
        step(2);
        rst_n = 1'b1;
        i_rsp_ready = 1'b1;
        step(10);
        check("post_mid_valid", 32'(o_rsp_valid), 32'd0);
        check("post_mid_busy", 32'(o_busy), 32'd0);
        check("post_mid_count", 32'(o_count), 32'd0);
        i_rsp_ready = 1'b0;
        send(32'd20, 32'd22, 3'b000, 32'd42, 1'b0, 1'b0);
        wait_valid();
        check("post_mid_r", o_rsp_r, 32'd42);
        handshake();
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
